// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: start bit, LSB-first data, optional
// even parity, stop bit; each bit held CLKS_PER_BIT cycles on a registered line.
module piso_tx #(
    parameter int   WIDTH        = 8,
    parameter int   CLKS_PER_BIT = 4,
    parameter logic IDLE_VAL     = 1'b1,
    parameter int   PARITY_EN    = 0
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] DATA,
    input  logic             VALID,
    output logic             READY,
    output logic             Q,
    output logic             notQ,
    output logic             DONE
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
    // The final stop cycle is the first IDLE cycle, so STOP itself lasts one cycle less.
    localparam logic [CW-1:0] STOP_LAST = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]       state;
    logic [CW-1:0]    cyc_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic             par_bit;
    logic             q_r;
    logic             done_r;
    logic             bit_end;
    logic             to_stop;

    assign shifted = shreg >> 1;
    assign bit_end = (cyc_cnt == CYC_LAST);
    assign to_stop = bit_end && ((state == S_PARITY) ||
                     (state == S_DATA && bit_cnt == BIT_LAST && PARITY_EN == 0));

    always_ff @(posedge C) begin
        if (R) begin
            state   <= S_IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            q_r     <= IDLE_VAL;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (VALID) begin
                        shreg   <= DATA;
                        par_bit <= ^DATA;
                        q_r     <= ~IDLE_VAL;
                        cyc_cnt <= '0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        q_r     <= shreg[0];
                        state   <= S_DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        shreg   <= shifted;
                        if (bit_cnt == BIT_LAST) begin
                            q_r   <= par_bit;
                            state <= S_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            q_r     <= shifted[0];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cyc_cnt == STOP_LAST) begin
                        cyc_cnt <= '0;
                        state   <= S_IDLE;
                        done_r  <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Entering the stop bit overrides the branch above; with one clock
            // per bit the stop cycle and the DONE cycle coincide.
            if (to_stop) begin
                q_r <= IDLE_VAL;
                if (CLKS_PER_BIT == 1) begin
                    state  <= S_IDLE;
                    done_r <= 1'b1;
                end else begin
                    state <= S_STOP;
                end
            end
        end
    end

    assign READY = (state == S_IDLE);
    assign Q     = q_r;
    assign notQ  = ~q_r;
    assign DONE  = done_r;
endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx over three configurations: a frame model
// expands each accepted word into per-cycle expectations of Q, READY and DONE.
module tb_piso_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic q;
        logic rdy;
        logic dn;
    } exp_t;

    task automatic chk(input string nm, input int g, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s actual=%b expected=%b at %0t", g, nm, act, exp, $time);
        end
    endtask

    genvar g;
    for (g = 0; g < 3; g++) begin : cfg
        localparam int   CPB  = (g == 2) ? 1 : 4;
        localparam int   PE   = (g == 1) ? 1 : 0;
        localparam logic IV   = (g == 2) ? 1'b0 : 1'b1;
        localparam int   NBIT = 8 + 2 + PE;
        localparam int   FLEN = NBIT * CPB;

        logic       r;
        logic       valid;
        logic [7:0] data;
        logic       ready;
        logic       q;
        logic       nq;
        logic       done;
        logic       armed;
        logic       fin_g;
        logic       cur_rdy = 1'b1;
        int         n_acc = 0;
        exp_t       sbq[$];
        exp_t       e_cur;
        logic [11:0] fb;

        piso_tx #(
            .WIDTH(8),
            .CLKS_PER_BIT(CPB),
            .IDLE_VAL(IV),
            .PARITY_EN(PE)
        ) dut (
            .C(clk),
            .R(r),
            .DATA(data),
            .VALID(valid),
            .READY(ready),
            .Q(q),
            .notQ(nq),
            .DONE(done)
        );

        // Frame model: an accepted word becomes FLEN cycles of expected line levels.
        always @(posedge clk) begin
            if (r) begin
                sbq.delete();
            end else if (valid && cur_rdy) begin
                fb = '0;
                fb[0] = ~IV;
                for (int i = 0; i < 8; i++) fb[1 + i] = data[i];
                if (PE != 0) fb[9] = ^data;
                fb[NBIT - 1] = IV;
                for (int c = 0; c < FLEN; c++)
                    sbq.push_back('{q: fb[c / CPB], rdy: (c == FLEN - 1), dn: (c == FLEN - 1)});
                n_acc++;
            end
        end

        // Monitor: one expectation consumed per cycle, idle when none pending.
        always @(negedge clk) begin
            if (sbq.size() > 0) e_cur = sbq.pop_front();
            else e_cur = '{q: IV, rdy: 1'b1, dn: 1'b0};
            cur_rdy = e_cur.rdy;
            if (armed) begin
                chk("Q", g, q, e_cur.q);
                chk("notQ", g, nq, ~e_cur.q);
                chk("READY", g, ready, e_cur.rdy);
                chk("DONE", g, done, e_cur.dn);
            end
        end

        task automatic step(input int n);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        endtask

        task automatic send(input logic [7:0] d);
            valid = 1'b1;
            data  = d;
            step(1);
            valid = 1'b0;
            data  = 8'($urandom);
        endtask

        task automatic wait_idle();
            int n = 0;
            while (sbq.size() != 0 && n < 500) begin
                step(1);
                n++;
            end
            if (n >= 500) begin
                checks++;
                errors++;
                $display("FAIL cfg%0d wait_idle timeout pending=%0d required=0", g, sbq.size());
            end
        endtask

        task automatic wait_accept(input int base);
            int n = 0;
            while (n_acc == base && n < 500) begin
                step(1);
                n++;
            end
            if (n >= 500) begin
                checks++;
                errors++;
                $display("FAIL cfg%0d accept timeout accepts=%0d required=%0d", g, n_acc, base + 1);
            end
        endtask

        initial begin
            fin_g = 1'b0;
            armed = 1'b0;
            r     = 1'b1;
            valid = 1'b1;
            data  = 8'h5A;
            step(2);
            armed = 1'b1;
            r     = 1'b0;
            valid = 1'b0;
            step(3);

            send(8'hA5);
            wait_idle();
            step(2);
            send(8'h07);
            wait_idle();
            step(1);

            // Mid-frame request must be ignored without disturbing the stream.
            send(8'hA5);
            step(10 * CPB / 4 + 2);
            valid = 1'b1;
            data  = 8'hFF;
            step(3);
            valid = 1'b0;
            wait_idle();
            step(2);

            // Back-to-back with VALID held high.
            begin
                int base;
                base  = n_acc;
                valid = 1'b1;
                data  = 8'h01;
                wait_accept(base);
                data  = 8'h80;
                wait_accept(base + 1);
                valid = 1'b0;
            end
            wait_idle();
            step(2);

            // Reset inside data bit 3, then a clean frame.
            send(8'hA5);
            step(4 * CPB);
            r = 1'b1;
            step(1);
            r = 1'b0;
            step(2);
            send(8'h3C);
            wait_idle();
            step(2);

            for (int i = 0; i < 400; i++) begin
                r     = ($urandom_range(0, 149) == 0);
                valid = ($urandom_range(0, 3) == 0);
                data  = 8'($urandom);
                step(1);
            end
            r     = 1'b0;
            valid = 1'b0;
            wait_idle();
            step(3);
            fin_g = 1'b1;
        end
    end

    initial begin
        int n = 0;
        while (!(cfg[0].fin_g && cfg[1].fin_g && cfg[2].fin_g) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("FAIL global timeout cycles=%0d limit=20000", n);
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 1..32.
REQ-002 Parameter CLKS_PER_BIT, default 4: clock cycles each serial bit is held, legal range 1..65535.
REQ-003 Parameter IDLE_VAL, default 1: line level driven on Q while idle and during the stop bit.
REQ-004 Parameter PARITY_EN, default 0: 1 inserts an even-parity bit after the data bits; 0 omits it.
REQ-005 C  input  1  clock; all state changes on its rising edge only.
REQ-006 R  input  1  synchronous, active-high reset, sampled on the rising edge of C.
REQ-007 DATA  input  WIDTH  parallel word to transmit, sampled on accept.
REQ-008 VALID  input  1  request to transmit DATA.
REQ-009 READY  output  1  high when a new word can be accepted.
REQ-010 Q  output  1  registered serial line.
REQ-011 notQ  output  1  logical inverse of Q at all times.
REQ-012 DONE  output  1  one-cycle pulse at the end of a frame.

Function
REQ-013 States: IDLE, START, DATA, PARITY, STOP. PARITY is entered only when PARITY_EN=1.
REQ-014 Accept: the word is accepted on a rising edge of C with VALID=1, READY=1 and R=0. DATA is latched into an internal shift register on that edge.
REQ-015 READY is 1 only in IDLE. It goes to 0 on the accept edge.
REQ-016 VALID while READY=0 is ignored. It is not queued, and changes on DATA during a frame do not affect the frame in progress.
REQ-017 Latency: Q drives the start bit, level !IDLE_VAL, from the accept edge, i.e. Q is valid in the first cycle after accept.
REQ-018 Each bit (start, every data bit, parity, stop) is held on Q for exactly CLKS_PER_BIT cycles. A bit counter and a cycle counter sequence the frame.
REQ-019 Data bits are sent LSB first: DATA[0] through DATA[WIDTH-1].
REQ-020 Parity bit = XOR of all latched data bits (even parity over data plus parity).
REQ-021 Stop bit level = IDLE_VAL.
REQ-022 Frame length = (WIDTH + 2 + PARITY_EN) * CLKS_PER_BIT cycles.
REQ-023 On the last cycle of STOP:
- the FSM returns to IDLE;
- READY rises and DONE is 1 for exactly one cycle (the first IDLE cycle);
- Q stays IDLE_VAL.
REQ-024 Back-to-back: VALID=1 in the first IDLE cycle, while DONE=1, is accepted. The next start bit follows with no extra idle cycle.
REQ-025 With CLKS_PER_BIT=1, every bit lasts one cycle and REQ-022 still holds.
REQ-026 Counters shall not wrap or overflow for any legal parameter value.
REQ-027 No combinational path from inputs to Q, notQ, READY or DONE.

Reset
REQ-028 While R=1 at a rising edge of C, on that edge:
- FSM goes to IDLE and counters clear;
- shift register clears to 0;
- Q=IDLE_VAL, notQ=!IDLE_VAL, READY=1, DONE=0.
REQ-029 R has priority over VALID. A word presented together with R=1 is not accepted.
REQ-030 Reset mid-frame aborts the frame immediately. DONE is not pulsed for the aborted frame.
REQ-031 Power-up (initial) register values equal the reset values.

Verification
REQ-032 WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=0, IDLE_VAL=1; DATA=0xA5, one-cycle VALID.
-> Q is 0 for 4 cycles (start).
-> Data bits 1,0,1,0,0,1,0,1, each held 4 cycles.
-> Stop bit 1 for 4 cycles.
-> DONE pulses in cycle 40 after accept; READY returns to 1 the same cycle.
REQ-033 PARITY_EN=1.
-> DATA=0xA5 gives parity bit 0 and a 44-cycle frame.
-> DATA=0x07 gives parity bit 1.
REQ-034 Mid-frame VALID with DATA=0xFF.
-> Ignored; the serial stream is unchanged from the 0xA5 pattern.
-> READY stays 0 until DONE.
REQ-035 Back-to-back.
-> VALID held high with 0x01 then 0x80 gives two contiguous frames: the second start bit begins the cycle after DONE.
REQ-036 Reset during data bit 3.
-> Next cycle: Q=1, notQ=0, READY=1, DONE=0, with no DONE pulse.
-> A new 0x3C sent afterwards is transmitted correctly.
REQ-037 IDLE_VAL=0, CLKS_PER_BIT=1, DATA=0x01.
-> Idle Q=0, start bit 1, data 1,0,0,0,0,0,0,0, stop 0.
-> 10-cycle frame; notQ is always the inverse of Q.
